// File: rtl/sym_vn_lut_loader.sv
// Streams DEPTH entry pairs into two LUT banks, one page per accepted beat, with abort and done pulse.
// Optional running XOR checksum of accepted data is enabled by defining SYM_VN_LOADER_CHECKSUM_EN.
module sym_vn_lut_loader #(
    parameter  int QUAN_SIZE       = 3,
    parameter  int ENTRY_ADDR      = 5,
    parameter  int MULTI_FRAME_NUM = 2,
    localparam int PAGE_W          = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM),
    localparam int DEPTH           = 2 ** PAGE_W
) (
    input  logic                   write_clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   start_offset,
    input  logic                   abort,
    input  logic [2*QUAN_SIZE-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [QUAN_SIZE-1:0]   lut_in_bank0,
    output logic [QUAN_SIZE-1:0]   lut_in_bank1,
    output logic [PAGE_W-1:0]      page_write_addr,
    output logic                   write_addr_offset,
    output logic                   we,
    output logic                   busy,
    output logic                   load_done,
    output logic [2*QUAN_SIZE-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [PAGE_W:0] LAST_CNT = (PAGE_W + 1)'(DEPTH - 1);

    state_t                 state_q;
    logic [PAGE_W:0]        cnt_q;
    logic [PAGE_W:0]        cnt_d;
    logic [QUAN_SIZE-1:0]   bank0_q;
    logic [QUAN_SIZE-1:0]   bank1_q;
    logic [PAGE_W-1:0]      addr_q;
    logic                   offset_q;
    logic                   we_q;
    logic                   done_q;
    logic                   accept;
    logic                   start_ok;

    // Abort outranks a simultaneous beat, so a beat only lands when abort is low.
    assign accept   = (state_q == LOAD) && in_valid && !abort;
    assign start_ok = (state_q == IDLE) && start;
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bank0_q  <= '0;
            bank1_q  <= '0;
            addr_q   <= '0;
            offset_q <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q  <= LOAD;
                        cnt_q    <= '0;
                        offset_q <= start_offset;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (accept) begin
                        bank0_q <= in_data[QUAN_SIZE-1:0];
                        bank1_q <= in_data[2*QUAN_SIZE-1:QUAN_SIZE];
                        addr_q  <= cnt_q[PAGE_W-1:0];
                        we_q    <= 1'b1;
                        cnt_q   <= cnt_d;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SYM_VN_LOADER_CHECKSUM_EN
    logic [2*QUAN_SIZE-1:0] chk_q;

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            chk_q <= '0;
        end else if (start_ok) begin
            chk_q <= '0;
        end else if (accept) begin
            chk_q <= chk_q ^ in_data;
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

    assign in_ready          = (state_q == LOAD);
    assign busy              = (state_q == LOAD) || (state_q == DONE);
    assign lut_in_bank0      = bank0_q;
    assign lut_in_bank1      = bank1_q;
    assign page_write_addr   = addr_q;
    assign write_addr_offset = offset_q;
    assign we                = we_q;
    assign load_done         = done_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader: directed loads checked every cycle against a scoreboard model.
// Checksum expectations follow SYM_VN_LOADER_CHECKSUM_EN when it is defined for the build.
module tb_sym_vn_lut_loader;

    localparam int DEPTH = 16;

    logic       write_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       start_offset = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] lut_in_bank0;
    logic [2:0] lut_in_bank1;
    logic [3:0] page_write_addr;
    logic       write_addr_offset;
    logic       we;
    logic       busy;
    logic       load_done;
    logic [5:0] checksum;

    int compareCount = 0;
    int failCount = 0;
    int weCount = 0;
    int doneCount = 0;
    logic [3:0] weLog[$];

    // Model: whether a load is accepting beats, whether the final write is showing, and expected outputs.
    bit         mLoad = 1'b0;
    bit         mDone = 1'b0;
    bit         wasDone = 1'b0;
    bit         compareEn = 1'b0;
    int         mEntries = 0;
    logic       mOff = 1'b0;
    logic       mWe = 1'b0;
    logic       mLd = 1'b0;
    logic [3:0] mAddr = '0;
    logic [2:0] mB0 = '0;
    logic [2:0] mB1 = '0;
    logic [5:0] mChk = '0;

    sym_vn_lut_loader dut (
        .write_clk         (write_clk),
        .rstn              (rstn),
        .start             (start),
        .start_offset      (start_offset),
        .abort             (abort),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we),
        .busy              (busy),
        .load_done         (load_done),
        .checksum          (checksum)
    );

    always #5 write_clk = ~write_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic so, input logic ab,
                                 input logic v, input logic [5:0] d);
        @(negedge write_clk);
        start        = s;
        start_offset = so;
        abort        = ab;
        in_valid     = v;
        in_data      = d;
    endtask

    // Expected outputs for the cycle after each rising edge.
    always @(posedge write_clk) begin
        if (!rstn) begin
            mLoad = 0; mDone = 0; mEntries = 0; mOff = 0; mWe = 0; mLd = 0;
            mAddr = '0; mB0 = '0; mB1 = '0; mChk = '0;
            compareEn = 1'b1;
        end else begin
            wasDone = mDone;
            mLd   = wasDone;
            mDone = 0;
            mWe   = 0;
            if (mLoad) begin
                if (abort) begin
                    mLoad = 0;
                end else if (in_valid) begin
                    mWe   = 1;
                    mAddr = mEntries[3:0];
                    mB0   = in_data[2:0];
                    mB1   = in_data[5:3];
                    mChk  = mChk ^ in_data;
                    mEntries++;
                    if (mEntries == DEPTH) begin
                        mLoad = 0;
                        mDone = 1;
                    end
                end
            end else if (!wasDone && start) begin
                mLoad    = 1;
                mEntries = 0;
                mOff     = start_offset;
                mChk     = '0;
            end
        end
    end

    always begin
        @(posedge write_clk);
        #1;
        if (compareEn) begin
            checkOutput("we", 32'(we), 32'(mWe));
            checkOutput("load_done", 32'(load_done), 32'(mLd));
            checkOutput("busy", 32'(busy), 32'(mLoad || mDone));
            checkOutput("in_ready", 32'(in_ready), 32'(mLoad));
            checkOutput("page_write_addr", 32'(page_write_addr), 32'(mAddr));
            checkOutput("lut_in_bank0", 32'(lut_in_bank0), 32'(mB0));
            checkOutput("lut_in_bank1", 32'(lut_in_bank1), 32'(mB1));
            checkOutput("write_addr_offset", 32'(write_addr_offset), 32'(mOff));
`ifdef SYM_VN_LOADER_CHECKSUM_EN
            checkOutput("checksum", 32'(checksum), 32'(mChk));
`else
            checkOutput("checksum", 32'(checksum), 32'(0));
`endif
            if (we === 1'b1) begin
                weCount++;
                weLog.push_back(page_write_addr);
            end
            if (load_done === 1'b1) doneCount++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset
        rstn = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("reset_we", 32'(we), 32'(0));
        checkOutput("reset_in_ready", 32'(in_ready), 32'(0));
        rstn = 1'b1;
        applyStimulus(0, 0, 0, 1, 6'h3F);
        checkOutput("idle_no_ready", 32'(in_ready), 32'(0));

        // Back-to-back full load with offset 1
        weCount = 0; doneCount = 0; weLog.delete();
        applyStimulus(1, 1, 0, 0, 6'h00);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, 6'(i));
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s1_last_addr", 32'(page_write_addr), 32'd15);
        checkOutput("s1_last_bank0", 32'(lut_in_bank0), 32'd7);
        checkOutput("s1_last_bank1", 32'(lut_in_bank1), 32'd1);
        checkOutput("s1_last_we", 32'(we), 32'd1);
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s1_done_pulse", 32'(load_done), 32'd1);
        checkOutput("s1_done_idle", 32'(busy), 32'd0);
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s1_done_once", 32'(load_done), 32'd0);
        checkOutput("s1_we_count", 32'(weCount), 32'd16);
        checkOutput("s1_done_count", 32'(doneCount), 32'd1);
        checkOutput("s1_offset", 32'(write_addr_offset), 32'd1);

        // Throttled load: in_valid toggles 1,0
        weCount = 0; doneCount = 0; weLog.delete();
        applyStimulus(1, 0, 0, 0, 6'h00);
        for (int i = 0; i < 2 * DEPTH; i++)
            applyStimulus(0, 0, 0, (i % 2) == 0, 6'((i / 2) + 20));
        repeat (3) applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s2_we_count", 32'(weCount), 32'd16);
        checkOutput("s2_done_count", 32'(doneCount), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            if (i < weLog.size()) checkOutput("s2_addr_order", 32'(weLog[i]), 32'(i));
        checkOutput("s2_offset", 32'(write_addr_offset), 32'd0);

        // Abort after 5 beats, then restart; a start during LOAD is ignored
        weCount = 0; doneCount = 0; weLog.delete();
        applyStimulus(1, 1, 0, 0, 6'h00);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 6'(i + 1));
        applyStimulus(0, 0, 1, 1, 6'h2D);
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s3_abort_busy", 32'(busy), 32'd0);
        checkOutput("s3_abort_we", 32'(we), 32'd0);
        checkOutput("s3_we_count", 32'(weCount), 32'd5);
        checkOutput("s3_last_addr", 32'(page_write_addr), 32'd4);
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s3_no_done", 32'(doneCount), 32'd0);
        weCount = 0; weLog.delete();
        applyStimulus(1, 1, 0, 0, 6'h00);
        applyStimulus(0, 0, 0, 1, 6'h09);
        applyStimulus(1, 0, 0, 1, 6'h0A);
        checkOutput("s3_restart_addr", 32'(page_write_addr), 32'd0);
        checkOutput("s3_restart_bank0", 32'(lut_in_bank0), 32'd1);
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(0, 0, 0, 1, 6'(i + 11));
        applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s4_offset_kept", 32'(write_addr_offset), 32'd1);
        repeat (2) applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s4_we_count", 32'(weCount), 32'd16);
        checkOutput("s4_done_count", 32'(doneCount), 32'd1);

        // Checksum: alternating 2A/15 cancels; a single 3F survives
        applyStimulus(1, 0, 0, 0, 6'h00);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, (i % 2 == 0) ? 6'h2A : 6'h15);
        repeat (3) applyStimulus(0, 0, 0, 0, 6'h00);
        checkOutput("s5_checksum_zero", 32'(checksum), 32'h00);
        applyStimulus(1, 0, 0, 0, 6'h00);
        applyStimulus(0, 0, 0, 1, 6'h3F);
        for (int i = 1; i < DEPTH; i++) applyStimulus(0, 0, 0, 1, 6'h00);
        repeat (3) applyStimulus(0, 0, 0, 0, 6'h00);
`ifdef SYM_VN_LOADER_CHECKSUM_EN
        checkOutput("s5_checksum_3f", 32'(checksum), 32'h3F);
`else
        checkOutput("s5_checksum_off", 32'(checksum), 32'h00);
`endif

        // Reset mid-load after 8 beats
        weCount = 0; doneCount = 0; weLog.delete();
        applyStimulus(1, 1, 0, 0, 6'h00);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 6'(i + 33));
        applyStimulus(0, 0, 0, 1, 6'h3E);
        rstn = 1'b0;
        applyStimulus(0, 0, 0, 1, 6'h3E);
        rstn = 1'b1;
        checkOutput("s6_rst_we", 32'(we), 32'd0);
        checkOutput("s6_rst_busy", 32'(busy), 32'd0);
        checkOutput("s6_rst_addr", 32'(page_write_addr), 32'd0);
        checkOutput("s6_rst_bank0", 32'(lut_in_bank0), 32'd0);
        checkOutput("s6_rst_bank1", 32'(lut_in_bank1), 32'd0);
        checkOutput("s6_rst_offset", 32'(write_addr_offset), 32'd0);
        checkOutput("s6_rst_checksum", 32'(checksum), 32'd0);
        repeat (3) applyStimulus(0, 0, 0, 1, 6'h11);
        checkOutput("s6_ready_low", 32'(in_ready), 32'd0);
        checkOutput("s6_we_count", 32'(weCount), 32'd8);
        checkOutput("s6_no_done", 32'(doneCount), 32'd0);
        applyStimulus(0, 0, 0, 0, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/sym_vn_lut_loader.md
SYM_VN_LUT_LOADER -- requirements
Module: sym_vn_lut_loader

Interface
REQ-001 Parameter QUAN_SIZE, default 3, is the LUT entry width per bank.
REQ-002 Parameter ENTRY_ADDR, default 5, is the full LUT entry address width.
REQ-003 Parameter MULTI_FRAME_NUM, default 2, is the number of frame pages; PAGE_W = ENTRY_ADDR-$clog2(MULTI_FRAME_NUM) (4 at defaults) and DEPTH = 2**PAGE_W (16 at defaults).
REQ-004 write_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle load request, honoured only in IDLE.
REQ-007 start_offset  input  1  frame page offset latched at an honoured start.
REQ-008 abort  input  1  cancels an in-progress load.
REQ-009 in_data  input  2*QUAN_SIZE  entry pair: [QUAN_SIZE-1:0] is bank0, [2*QUAN_SIZE-1:QUAN_SIZE] is bank1.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  loader accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-012 lut_in_bank0, lut_in_bank1  output  QUAN_SIZE each  write data to the two LUT banks.
REQ-013 page_write_addr  output  PAGE_W  write page address.
REQ-014 write_addr_offset  output  1  write frame offset.
REQ-015 we  output  1  LUT write enable.
REQ-016 busy  output  1  high in LOAD and DONE.
REQ-017 load_done  output  1  one-cycle pulse on completion of a full load.
REQ-018 checksum  output  2*QUAN_SIZE  running XOR of accepted in_data (see Configuration).

Function
REQ-019 FSM states: IDLE, LOAD, DONE; IDLE->LOAD on start, LOAD->DONE on the DEPTH-th accepted beat, LOAD->IDLE on abort, DONE->IDLE unconditionally after one cycle.
REQ-020 in_ready is 1 only in LOAD and is combinational from state; in_valid is never required to wait for in_ready.
REQ-021 At an honoured start: entry counter <= 0, write_addr_offset <= start_offset, checksum <= 0; start outside IDLE is ignored.
REQ-022 Each accepted beat registers lut_in_bank0/1 <= in_data halves, page_write_addr <= counter, we <= 1, counter <= counter+1; the outputs are visible in the next cycle (latency 1).
REQ-023 A cycle without an accepted beat registers we <= 0; lut_in_bank*/page_write_addr hold their values.
REQ-024 Entries are written in ascending page order 0..DEPTH-1; the counter is PAGE_W+1 bits wide and never wraps within a load.
REQ-025 The edge that accepts beat DEPTH-1 moves the FSM to DONE; in DONE we is 1 for that last entry, and the following edge sets load_done=1 for exactly one cycle, in IDLE.
REQ-026 abort in LOAD has priority over a simultaneous beat: the beat is not accepted, we <= 0, state <= IDLE, load_done stays 0; abort in IDLE/DONE has no effect.
REQ-027 start in the cycle in which load_done=1 is honoured (state is IDLE).
REQ-028 write_addr_offset is stable from start until the next honoured start.

Reset
REQ-029 While rstn=0 at a rising edge: state=IDLE, counter=0, we=0, load_done=0, busy=0, in_ready=0, lut_in_bank0/1=0, page_write_addr=0, write_addr_offset=0, checksum=0.
REQ-030 Reset mid-load discards the load with no further we and no load_done pulse.

Configuration
REQ-031 With macro SYM_VN_LOADER_CHECKSUM_EN defined, checksum <= checksum XOR in_data on each accepted beat and holds otherwise (cleared by start and reset); without it, checksum is constant 0 and no accumulator register exists.

Verification
REQ-032 Reset, start=1 with start_offset=1, then 16 back-to-back beats in_data=0..15 -> we high 16 cycles, page_write_addr 0..15, lut_in_bank0=in_data[2:0], lut_in_bank1=in_data[5:3], write_addr_offset=1, load_done pulse one cycle after the last we.
REQ-033 Same load with in_valid toggling 1,0 -> we only in the cycles following accepted beats, addresses still 0..15 with no gaps or repeats.
REQ-034 abort asserted with in_valid=1 after 5 beats -> beat 6 not written, busy=0 next cycle, no load_done; new start restarts at page_write_addr=0.
REQ-035 start pulsed during LOAD with start_offset=0 after starting with 1 -> ignored, write_addr_offset stays 1, counter continues.
REQ-036 With SYM_VN_LOADER_CHECKSUM_EN: 16 beats of 6'h2A then 6'h15 alternating -> checksum=0 after load; with a single extra 6'h3F loaded into a fresh load of all-zero data except entry 0 -> checksum=6'h3F; without the macro checksum=0 throughout.
REQ-037 rstn=0 for one cycle after beat 8 -> all outputs zero next cycle, no load_done, in_ready=0 until next start.
